dmem_responder: RTL and testbench

Memory-side responder for the single-cycle core's data port. It serves loads and stores issued on `MemWrite`/`Mem_WrAddr`/`Mem_WrData`/`ReadData`, and contains:
- a word-addressed RAM;
- a memory-mapped transmit FIFO drained through a valid/ready byte stream;
- an optional free-running cycle counter.

Reads are combinational so the core completes a load in the same cycle; all state updates occur on the rising clock edge.

---
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, MMIO transmit FIFO and cycle counter.
// Define DMEM_CYCLE_COUNTER_EN to build the free-running CYCLE counter.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   ram_q [DEPTH_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          ram_hit, mmio_hit, wr_en;
    logic [AW-1:0] ram_idx;
    logic [1:0]    reg_sel;
    logic          tx_wr, st_wr, cyc_wr;
    logic          empty, full, pop, push_ok;
    logic [31:0]   status, cycle_val;
    logic          unused_addr;

    assign ram_hit     = (Mem_WrAddr[31:AW+2] == '0);
    assign ram_idx     = Mem_WrAddr[AW+1:2];
    assign mmio_hit    = (Mem_WrAddr[31:4] == MMIO_BASE[31:4]);
    assign reg_sel     = Mem_WrAddr[3:2];
    assign unused_addr = ^Mem_WrAddr[1:0];

    // Stores presented during reset are dropped everywhere.
    assign wr_en  = MemWrite && !reset;
    assign tx_wr  = wr_en && mmio_hit && (reg_sel == 2'd0);
    assign st_wr  = wr_en && mmio_hit && (reg_sel == 2'd1);
    assign cyc_wr = wr_en && mmio_hit && (reg_sel == 2'd2);

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = !empty && out_ready;
    assign push_ok = tx_wr && (!full || pop);

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (pop)
            rptr_d = rptr_q + PW'(1);
        if (push_ok)
            wptr_d = wptr_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (tx_wr && !push_ok)
            ovf_d = 1'b1;
        else if (st_wr)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage arrays carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en && ram_hit)
            ram_q[ram_idx] <= Mem_WrData;
        if (push_ok)
            fifo_q[wptr_q] <= Mem_WrData[7:0];
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_q, cycle_d;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (cyc_wr)
            cycle_d = Mem_WrData;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cycle_q <= '0;
        else
            cycle_q <= cycle_d;
    end

    assign cycle_val = cycle_q;
`else
    logic unused_cyc;
    assign unused_cyc = cyc_wr;
    assign cycle_val  = '0;
`endif

    // Occupancy sits in [15:8]; flags in [2:0].
    assign status = {16'h0, 8'(count_q), 5'h0, ovf_q, full, empty};

    always_comb begin
        ReadData = '0;
        if (ram_hit) begin
            ReadData = ram_q[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                2'd1:    ReadData = status;
                2'd2:    ReadData = cycle_val;
                default: ReadData = '0;
            endcase
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? 8'h00 : fifo_q[rptr_q];

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a queue-based reference model.
// Directed scenarios first, then random loads/stores/resets.
module tb_dmem_responder;

    localparam logic [31:0] TX = 32'hFFFF_0000;
    localparam logic [31:0] ST = 32'hFFFF_0004;
    localparam logic [31:0] CY = 32'hFFFF_0008;
    localparam logic [31:0] NA = 32'hFFFF_000C;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [31:0] ReadData;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    dmem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Mem_WrAddr(Mem_WrAddr),
        .Mem_WrData(Mem_WrData),
        .ReadData  (ReadData),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ram_m [int unsigned];
    logic [7:0]  q_m [$];
    logic        ovf_m;
    logic [31:0] cyc_m;

    logic [31:0] s_rd;
    logic [7:0]  s_od;
    logic        s_ov;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic bit is_ram(input logic [31:0] a);
        return a < 32'd4096;
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return (a >= 32'hFFFF_0000) && (a <= 32'hFFFF_000F);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned n;
        n = q_m.size();
        if (is_ram(a))
            return ram_m[a / 4];
        if (!is_mmio(a))
            return 32'h0;
        case ((a - TX) / 4)
            1: return n * 256 + (ovf_m ? 4 : 0) + (n == 4 ? 2 : 0)
                   + (n == 0 ? 1 : 0);
`ifdef DMEM_CYCLE_COUNTER_EN
            2: return cyc_m;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_update(input logic we, input logic [31:0] a,
                                input logic [31:0] d, input logic rdy,
                                input logic rst);
        bit pop, acc;
        logic [31:0] nc;
        if (rst) begin
            q_m.delete();
            ovf_m = 1'b0;
            cyc_m = 32'h0;
        end else begin
            pop = (q_m.size() != 0) && rdy;
            acc = 1'b0;
            nc  = cyc_m + 32'd1;
            if (we && is_ram(a)) begin
                ram_m[a / 4] = d;
            end else if (we && is_mmio(a)) begin
                case ((a - TX) / 4)
                    0: if (q_m.size() < 4 || pop) acc = 1'b1;
                       else ovf_m = 1'b1;
                    1: ovf_m = 1'b0;
                    2: nc = d;
                    default: ;
                endcase
            end
            if (pop)
                void'(q_m.pop_front());
            if (acc)
                q_m.push_back(d[7:0]);
            cyc_m = nc;
        end
    endtask

    task automatic step(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy,
                        input logic rst);
        @(negedge clk);
        MemWrite   = we;
        Mem_WrAddr = a;
        Mem_WrData = d;
        out_ready  = rdy;
        reset      = rst;
        #1;
        s_rd = ReadData;
        s_od = out_data;
        s_ov = out_valid;
        if (!is_ram(a) || ram_m.exists(a / 4))
            check("rdata", s_rd, model_read(a));
        check("valid", 32'(s_ov), 32'(q_m.size() != 0));
        check("odata", 32'(s_od), q_m.size() != 0 ? 32'(q_m[0]) : 32'h0);
        @(posedge clk);
        model_update(we, a, d, rdy, rst);
    endtask

    initial begin
        logic [31:0] a;
        reset      = 1'b1;
        MemWrite   = 1'b0;
        Mem_WrAddr = 32'h0;
        Mem_WrData = 32'h0;
        out_ready  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        model_update(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        step(0, ST, 0, 0, 0);
        check("rst_status", s_rd, 32'h0000_0001);
        check("rst_valid", 32'(s_ov), 32'h0);

        step(1, 32'h10, 32'hDEADBEEF, 0, 0);
        step(0, 32'h10, 0, 0, 0);
        check("ram_load", s_rd, 32'hDEADBEEF);
        step(0, 32'h13, 0, 0, 0);
        check("ram_load_lsb", s_rd, 32'hDEADBEEF);
        step(0, 32'h1000, 0, 0, 0);
        check("ram_oob", s_rd, 32'h0);

        for (int i = 0; i < 5; i++)
            step(1, TX, 32'h41 + i, 0, 0);
        step(0, ST, 0, 0, 0);
        check("fill_status", s_rd, 32'h0000_0406);
        for (int i = 0; i < 4; i++) begin
            step(0, NA, 0, 1, 0);
            check("drain_data", 32'(s_od), 32'h41 + i);
        end
        step(0, ST, 0, 1, 0);
        check("drain_valid", 32'(s_ov), 32'h0);
        check("drain_empty", 32'(s_rd[0]), 32'h1);

        step(1, TX, 32'h61, 0, 0);
        step(1, TX, 32'h62, 0, 0);
        step(1, ST, 32'hFFFF_FFFF, 0, 0);
        step(0, ST, 0, 0, 0);
        check("ovf_clear", s_rd, 32'h0000_0200);
        step(0, NA, 0, 1, 0);
        check("ovf_keep0", 32'(s_od), 32'h61);
        step(0, NA, 0, 1, 0);
        check("ovf_keep1", 32'(s_od), 32'h62);

        for (int i = 0; i < 4; i++)
            step(1, TX, 32'h71 + i, 0, 0);
        step(1, TX, 32'h55, 1, 0);
        step(0, ST, 0, 0, 0);
        check("pp_status", s_rd, 32'h0000_0402);
        for (int i = 0; i < 4; i++) begin
            step(0, NA, 0, 1, 0);
            check("pp_data", 32'(s_od), i == 3 ? 32'h55 : 32'h72 + i);
        end

        step(1, CY, 32'hFFFF_FFFE, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, CY, 0, 0, 0);
`ifdef DMEM_CYCLE_COUNTER_EN
            check("cycle", s_rd, 32'hFFFF_FFFE + i);
`else
            check("cycle_off", s_rd, 32'h0);
`endif
        end

        step(1, 32'h20, 32'h1234_5678, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, TX, 32'h81 + i, 0, 0);
        step(1, 32'h20, 32'h0000_0BAD, 1, 1);
        step(0, CY, 0, 0, 0);
        check("mid_valid", 32'(s_ov), 32'h0);
        check("mid_cycle", s_rd, 32'h0);
        step(0, ST, 0, 0, 0);
        check("mid_status", s_rd, 32'h0000_0001);
        step(0, 32'h20, 0, 0, 0);
        check("mid_ram", s_rd, 32'h1234_5678);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 255);
                1: a = TX | $urandom_range(0, 15);
                2: a = TX + $urandom_range(0, 1) * 4;
                default: a = $urandom;
            endcase
            step(1'($urandom_range(0, 1)), a, $urandom,
                 1'($urandom_range(0, 2) == 0),
                 $urandom_range(0, 99) == 0);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
